// File: rtl/instr_feeder_pkg.sv
// Shared processor definitions: word width, opcodes and the immediate-operand test.
// Feeder FSM states; HOLD exists only when FEEDER_STEP_EN is defined.
package proc_pkg;

  localparam int WORD_W = 9;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_SUBI = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_IMM,
    S_WAIT,
    S_HALT
`ifdef FEEDER_STEP_EN
    , S_HOLD
`endif
  } feeder_state_t;

  function automatic logic has_imm(input logic [2:0] op);
    return (op == OP_MVI) || (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

endpackage

// File: rtl/instr_feeder_if.sv
// Feeder-to-processor link: instruction/immediate word, run request and completion strobe.
interface instr_feeder_if #(
  parameter int WORD_W = proc_pkg::WORD_W
);
  logic [WORD_W-1:0] DIN;
  logic              Run;
  logic              Done;

  modport master (output DIN, output Run, input Done);
  modport slave  (input DIN, input Run, output Done);
endinterface

// File: rtl/instr_feeder_prog_ram.sv
// Program store: synchronous write, asynchronous read so FETCH sees the word at pc directly.
module prog_ram #(
  parameter int WORD_W = 9,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_feeder.sv
// Instruction feeder for the 9-bit processor: program RAM, pc and Run/DIN sequencing.
// Optional single-step mode (step_mode/Step ports, HOLD state) under `define FEEDER_STEP_EN.
module instr_feeder
  import proc_pkg::*;
#(
  parameter int WORD_W = proc_pkg::WORD_W,
  parameter int ADDR_W = 5
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              Start,
  input  logic [ADDR_W-1:0] last_addr,
`ifdef FEEDER_STEP_EN
  input  logic              step_mode,
  input  logic              Step,
`endif
  instr_feeder_if.master    bus,
  output logic              Halted,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        instr_cnt
);

  feeder_state_t     state;
  feeder_state_t     fetch_entry;
  logic              run;
  logic              idle_like;
  logic [WORD_W-1:0] rd_data;
  logic [ADDR_W-1:0] pc_inc;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign idle_like = (state == S_IDLE) || (state == S_HALT);
  assign pc_inc    = pc + 1'b1;

`ifdef FEEDER_STEP_EN
  assign fetch_entry = step_mode ? S_HOLD : S_FETCH;
`else
  assign fetch_entry = S_FETCH;
`endif

  prog_ram #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (Clock),
    .we    (wr_en && idle_like),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (pc),
    .rdata (rd_data)
  );

  // DIN follows the async RAM read so a write landing with Start is visible in FETCH.
  assign bus.DIN = ((state == S_FETCH) || (state == S_IMM)) ? rd_data : '0;
  assign bus.Run = run;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state     <= S_IDLE;
      pc        <= '0;
      instr_cnt <= '0;
      run       <= 1'b0;
      Halted    <= 1'b0;
    end else begin
      run <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (Start) begin
            pc        <= '0;
            instr_cnt <= '0;
            Halted    <= 1'b0;
            state     <= fetch_entry;
            run       <= (fetch_entry == S_FETCH);
          end
        end
`ifdef FEEDER_STEP_EN
        S_HOLD: begin
          if (Step) begin
            state <= S_FETCH;
            run   <= 1'b1;
          end
        end
`endif
        S_FETCH: begin
          if (has_imm(rd_data[WORD_W-1 -: 3])) begin
            state <= S_IMM;
            pc    <= pc_inc;
          end else begin
            state <= S_WAIT;
          end
        end
        S_IMM, S_WAIT: begin
          // Done is acted on in the cycle it appears so the next FETCH meets processor T0.
          if (bus.Done) begin
            instr_cnt <= sat_inc(instr_cnt);
            if (pc == last_addr) begin
              state  <= S_HALT;
              Halted <= 1'b1;
            end else begin
              pc    <= pc_inc;
              state <= fetch_entry;
              run   <= (fetch_entry == S_FETCH);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: a small processor stand-in plus an instruction-level feeder model.
module tb_instr_feeder;
  import proc_pkg::*;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       Resetn, wr_en, Start, step_mode, Step, extra_done;
  logic [4:0] wr_addr, last_addr;
  logic [8:0] wr_data;
  logic       Halted;
  logic [4:0] pc;
  logic [7:0] instr_cnt;
  int         checks = 0;
  int         errors = 0;
  logic       armed = 1'b0;

  always #5 clk = ~clk;

  instr_feeder_if bus ();

  instr_feeder dut (
    .Clock     (clk),
    .Resetn    (Resetn),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .Start     (Start),
    .last_addr (last_addr),
`ifdef FEEDER_STEP_EN
    .step_mode (step_mode),
    .Step      (Step),
`endif
    .bus       (bus),
    .Halted    (Halted),
    .pc        (pc),
    .instr_cnt (instr_cnt)
  );

  // Processor stand-in: T0 latches IR on Run; 1-cycle ops finish in T1, others in T3.
  logic [1:0] t;
  logic [8:0] ir, g;
  logic [8:0] R [8];
  logic [2:0] eop, ex, ey;
  logic       emu_done;
  int         run_pulses = 0;

  assign eop = ir[8:6];
  assign ex  = ir[5:3];
  assign ey  = ir[2:0];

  always_comb begin
    emu_done = 1'b0;
    if (t == 2'd1 && (eop == OP_MV || eop == OP_MVI || eop[2:1] == 2'b11)) emu_done = 1'b1;
    if (t == 2'd3 && (eop == OP_ADD || eop == OP_SUB || eop == OP_ADDI || eop == OP_SUBI)) emu_done = 1'b1;
  end

  assign bus.Done = emu_done | extra_done;

  always @(posedge clk) begin
    if (bus.Run) run_pulses <= run_pulses + 1;
    if (!Resetn) begin
      t <= 2'd0;
    end else if (t == 2'd0) begin
      if (bus.Run) begin
        ir <= bus.DIN;
        t  <= 2'd1;
      end
    end else if (emu_done) begin
      t <= 2'd0;
      case (eop)
        OP_MV:   R[ex] <= R[ey];
        OP_MVI:  R[ex] <= bus.DIN;
        OP_ADD:  R[ex] <= R[ex] + R[ey];
        OP_SUB:  R[ex] <= R[ex] - R[ey];
        OP_ADDI: R[ex] <= R[ex] + g;
        OP_SUBI: R[ex] <= R[ex] - g;
        default: ;
      endcase
    end else begin
      t <= t + 2'd1;
      if (t == 2'd2) g <= bus.DIN;
    end
  end

  // Instruction-level model: ipc is the address of the current instruction word.
  logic [8:0] mem_m [DEPTH];
  logic       run_on, halted_m, fetch_due, in_instr, hold_m;
  logic [4:0] ipc;
  logic [7:0] cnt_m;

  function automatic logic [4:0] end_of(input logic [4:0] a);
    logic [8:0] w;
    w = mem_m[a];
    return has_imm(w[8:6]) ? a + 5'd1 : a;
  endfunction

  function automatic logic in_imm_phase();
    logic [8:0] w;
    w = mem_m[ipc];
    return in_instr && has_imm(w[8:6]);
  endfunction

  always @(posedge clk) begin
    if (!Resetn) begin
      run_on <= 1'b0; halted_m <= 1'b0; fetch_due <= 1'b0;
      in_instr <= 1'b0; hold_m <= 1'b0; ipc <= 5'd0; cnt_m <= 8'd0;
    end else if (!run_on) begin
      if (wr_en) mem_m[wr_addr] <= wr_data;
      if (Start) begin
        run_on <= 1'b1; halted_m <= 1'b0; ipc <= 5'd0; cnt_m <= 8'd0;
        hold_m <= step_mode; fetch_due <= !step_mode; in_instr <= 1'b0;
      end
    end else if (hold_m) begin
      if (Step) begin
        hold_m    <= 1'b0;
        fetch_due <= 1'b1;
      end
    end else if (fetch_due) begin
      fetch_due <= 1'b0;
      in_instr  <= 1'b1;
    end else if (in_instr && bus.Done) begin
      in_instr <= 1'b0;
      if (cnt_m != 8'hFF) cnt_m <= cnt_m + 8'd1;
      if (end_of(ipc) == last_addr) begin
        run_on   <= 1'b0;
        halted_m <= 1'b1;
        ipc      <= end_of(ipc);
      end else begin
        ipc       <= end_of(ipc) + 5'd1;
        hold_m    <= step_mode;
        fetch_due <= !step_mode;
      end
    end
  end

  always @(posedge clk) begin
    logic [8:0] w, exp_din;
    logic [4:0] nx, exp_pc;
    #2;
    if (armed) begin
      w       = mem_m[ipc];
      nx      = ipc + 5'd1;
      exp_din = fetch_due ? w : (in_instr && has_imm(w[8:6])) ? mem_m[nx] : 9'd0;
      exp_pc  = in_instr ? end_of(ipc) : ipc;
      checks++;
      if (bus.Run !== fetch_due || bus.DIN !== exp_din || pc !== exp_pc ||
          instr_cnt !== cnt_m || Halted !== halted_m) begin
        errors++;
        $display("FAIL cycle @%0t: run %b want %b, din %h want %h, pc %0d want %0d, cnt %0d want %0d, halted %b want %b",
                 $time, bus.Run, fetch_due, bus.DIN, exp_din, pc, exp_pc, instr_cnt, cnt_m, Halted, halted_m);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [4:0] a, input logic [8:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_prog();
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (Halted === 1'b1) break;
      @(negedge clk);
    end
    chk(name, Halted, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic seen, found;
    Resetn = 1'b0; wr_en = 1'b0; Start = 1'b0; step_mode = 1'b0; Step = 1'b0;
    extra_done = 1'b0; wr_addr = 5'd0; wr_data = 9'd0; last_addr = 5'd0;
    repeat (2) @(negedge clk);
    armed = 1'b1;
    chk("rst_run", bus.Run, 0);
    chk("rst_din", bus.DIN, 0);
    chk("rst_pc", pc, 0);
    chk("rst_cnt", instr_cnt, 0);
    chk("rst_halted", Halted, 0);
    Resetn = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_word(5'(i), 9'd0);

    extra_done = 1'b1; @(negedge clk); extra_done = 1'b0;
    chk("idle_done_cnt", instr_cnt, 0);

    // mvi R0,5 then halt
    write_word(5'd0, 9'h040); write_word(5'd1, 9'd5); last_addr = 5'd1;
    start_prog();
    wait_halt("t1_halt", 20);
    chk("t1_r0", R[0], 9'd5);
    chk("t1_cnt", instr_cnt, 1);
    chk("t1_pc", pc, 1);
    extra_done = 1'b1; @(negedge clk); extra_done = 1'b0;
    chk("halt_done_cnt", instr_cnt, 1);

    // four-instruction program; word 0 written together with Start
    write_word(5'd1, 9'd5); write_word(5'd2, 9'h048); write_word(5'd3, 9'd3);
    write_word(5'd4, 9'h081); write_word(5'd5, 9'h0C8); last_addr = 5'd5;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 9'h040; Start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; Start = 1'b0;
    extra_done = 1'b1; @(negedge clk); extra_done = 1'b0;
    wait_halt("t2_halt", 60);
    chk("t2_r0", R[0], 9'd8);
    chk("t2_r1", R[1], 9'h1FB);
    chk("t2_cnt", instr_cnt, 4);

    // mvi R2,1 ; addi R2,7
    write_word(5'd0, 9'h050); write_word(5'd1, 9'd1);
    write_word(5'd2, 9'h110); write_word(5'd3, 9'd7); last_addr = 5'd3;
    start_prog();
    for (int i = 0; i < 30; i++) begin
      if (Halted === 1'b1) break;
      if (ir == 9'h110 && t != 2'd0) chk("addi_din", bus.DIN, 9'd7);
      @(negedge clk);
    end
    chk("t3_halt", Halted, 1);
    chk("t3_r2", R[2], 9'd8);
    chk("t3_cnt", instr_cnt, 2);

    // Start/wr_en mid-program are ignored
    write_word(5'd0, 9'h040); write_word(5'd1, 9'd2); write_word(5'd2, 9'h048);
    write_word(5'd3, 9'd4); write_word(5'd4, 9'h081); last_addr = 5'd4;
    start_prog();
    repeat (3) @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 9'h0C8; Start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; Start = 1'b0;
    wait_halt("t4_halt", 60);
    chk("t4_r0", R[0], 9'd6);
    chk("t4_r1", R[1], 9'd4);
    chk("t4_cnt", instr_cnt, 3);

    // reset while the immediate is presented
    start_prog();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_imm_phase()) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("t4_imm_reached", found, 1);
    Resetn = 1'b0;
    @(negedge clk);
    Resetn = 1'b1;
    chk("mid_rst_run", bus.Run, 0);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_din", bus.DIN, 0);
    chk("mid_rst_halted", Halted, 0);

    // last_addr = DEPTH-1 with mvi at the top: immediate wraps to ram[0]; counter saturates
    write_word(5'd0, 9'h1AB);
    for (int i = 1; i < DEPTH - 1; i++) write_word(5'(i), 9'h000);
    write_word(5'd31, 9'h058); last_addr = 5'd31;
    start_prog();
    seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!seen && t == 2'd1 && ir == 9'h058) begin
        seen = 1'b1;
        chk("wrap_pc", pc, 0);
        chk("wrap_din", bus.DIN, 9'h1AB);
      end
      @(negedge clk);
    end
    chk("wrap_seen", seen, 1);
    chk("wrap_r3", R[3], 9'h1AB);
    chk("sat_cnt", instr_cnt, 8'hFF);
    chk("wrap_not_halted", Halted, 0);
    Resetn = 1'b0; @(negedge clk); Resetn = 1'b1;

`ifdef FEEDER_STEP_EN
    for (int i = 0; i < 3; i++) write_word(5'(i), 9'h000);
    last_addr = 5'd2; step_mode = 1'b1;
    base = run_pulses;
    start_prog();
    for (int k = 0; k < 3; k++) begin
      repeat (3) @(negedge clk);
      Step = 1'b1; @(negedge clk); Step = 1'b0;
      repeat (3) @(negedge clk);
    end
    chk("step_halt", Halted, 1);
    chk("step_runs", run_pulses - base, 3);
    Step = 1'b1; @(negedge clk); Step = 1'b0;
    repeat (2) @(negedge clk);
    chk("step_after_halt", run_pulses - base, 3);
    step_mode = 1'b0;
`else
    base = run_pulses;
    chk("no_run_idle", run_pulses - base, 0);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
